// File: rtl/split_data.sv
`default_nettype none
// ============================================================================
//  Module      : split_data
//  Description : Read-path pixel unpacker. Takes wide memory words (OSIZE
//                bits) and emits a stream of narrow pixels (ISIZE bits)
//                from a continuous MSB-first bit stream. A pixel may span
//                two consecutive words. Residual bits left over at a line
//                end are discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module split_data #(
  parameter int ISIZE = 24,
  parameter int OSIZE = 256,
  parameter int CW    = $clog2(OSIZE + ISIZE)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ialign,
  input  logic             ivalid,
  output logic             iready,
  input  logic [OSIZE-1:0] idata,
  input  logic             ilast,
  output logic             ovalid,
  input  logic             oready,
  output logic [ISIZE-1:0] odata,
  output logic             olast
);

  // Buffer holds at most ISIZE-1 residual bits plus one full word.
  localparam int BW = OSIZE + ISIZE - 1;

  localparam logic [CW-1:0] C_ISIZE   = CW'(ISIZE);
  localparam logic [CW-1:0] C_OSIZE   = CW'(OSIZE);
  // One bit wider so that 2*ISIZE is representable even when ISIZE == OSIZE.
  localparam logic [CW:0]   C_TWO_ISZ = (CW + 1)'(2 * ISIZE);

  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  logic [BW-1:0] w_word;
  logic          w_load;
  logic          w_pop;

  // Incoming word placed MSB-aligned in a buffer-wide vector, low bits zero.
  always_comb begin
    w_word                 = '0;
    w_word[BW-1 -: OSIZE]  = idata;
  end

  // Handshake and pixel outputs, all derived from registered state
  // (plus ialign); oready never reaches iready.
  always_comb begin
    iready = (cnt_q < C_ISIZE) || ialign;
    ovalid = (cnt_q >= C_ISIZE) && !ialign;
    olast  = ovalid && last_q && ({1'b0, cnt_q} < C_TWO_ISZ);
    odata  = buf_q[BW-1 -: ISIZE];
    w_load = ivalid && iready && !ialign;
    w_pop  = ovalid && oready;
  end

  // Next-state: flush/reload on ialign, otherwise load or pop (never both,
  // since load needs cnt < ISIZE and pop needs cnt >= ISIZE).
  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (ialign) begin
      buf_d  = '0;
      cnt_d  = '0;
      last_d = 1'b0;
      if (ivalid) begin
        buf_d  = w_word;
        cnt_d  = C_OSIZE;
        last_d = ilast;
      end
    end else if (w_load) begin
      // Bits below the residue are always zero, so OR appends the word
      // directly behind the residual bits.
      buf_d  = buf_q | (w_word >> cnt_q);
      cnt_d  = cnt_q + C_OSIZE;
      last_d = ilast;
    end else if (w_pop) begin
      if (olast) begin
        // Final pixel of the line: drop any leftover bits.
        buf_d  = '0;
        cnt_d  = '0;
        last_d = 1'b0;
      end else begin
        buf_d  = buf_q << ISIZE;
        cnt_d  = cnt_q - C_ISIZE;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_split_data.sv
`default_nettype none
// ============================================================================
//  Module      : tb_split_data
//  Description : Self-checking bench for split_data. A bit-queue reference
//                model predicts every output on every cycle; directed
//                scenarios pin the model with hand-computed pixel values,
//                then a randomized phase exercises handshakes, ilast and
//                ialign.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_split_data;

  localparam int ISIZE = 24;
  localparam int OSIZE = 256;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             ialign = 1'b0;
  logic             ivalid = 1'b0;
  logic             iready;
  logic [OSIZE-1:0] idata = '0;
  logic             ilast = 1'b0;
  logic             ovalid;
  logic             oready = 1'b1;
  logic [ISIZE-1:0] odata;
  logic             olast;

  int checks = 0;
  int errors = 0;

  // 0: oready held high, 1: toggle every cycle, 2: random
  int or_mode = 0;

  split_data #(.ISIZE(ISIZE), .OSIZE(OSIZE)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .ialign (ialign),
    .ivalid (ivalid),
    .iready (iready),
    .idata  (idata),
    .ilast  (ilast),
    .ovalid (ovalid),
    .oready (oready),
    .odata  (odata),
    .olast  (olast)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: the buffered bit stream -------------
  bit mq[$];
  bit mlast = 1'b0;
  bit mok   = 1'b0;
  int mn;

  always @(posedge clock) begin
    if (!rst_n) begin
      mq.delete();
      mlast = 1'b0;
      mok   = 1'b1;
    end else if (mok) begin
      mn = mq.size();
      if (ialign) begin
        mq.delete();
        mlast = 1'b0;
        if (ivalid) begin
          for (int i = OSIZE - 1; i >= 0; i--) mq.push_back(idata[i]);
          mlast = ilast;
        end
      end else if (ivalid && mn < ISIZE) begin
        for (int i = OSIZE - 1; i >= 0; i--) mq.push_back(idata[i]);
        mlast = ilast;
      end else if (mn >= ISIZE && oready) begin
        if (mlast && mn < 2 * ISIZE) begin
          mq.delete();
          mlast = 1'b0;
        end else begin
          repeat (ISIZE) void'(mq.pop_front());
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ------------------
  logic [ISIZE-1:0] e_odata;
  logic             e_ovalid, e_iready, e_olast;
  logic [ISIZE:0]   cap[$];   // {olast, odata} of every consumed pixel

  always @(negedge clock) begin
    if (mok) begin
      e_ovalid = (mq.size() >= ISIZE) && !ialign;
      e_iready = (mq.size() < ISIZE) || ialign;
      e_olast  = e_ovalid && mlast && (mq.size() < 2 * ISIZE);
      for (int i = 0; i < ISIZE; i++)
        e_odata[ISIZE-1-i] = (i < mq.size()) ? mq[i] : 1'b0;
      chk("iready", 32'(iready), 32'(e_iready));
      chk("ovalid", 32'(ovalid), 32'(e_ovalid));
      chk("olast",  32'(olast),  32'(e_olast));
      chk("odata",  32'(odata),  32'(e_odata));
    end
    if (rst_n && ovalid && oready) cap.push_back({olast, odata});
  end

  // oready pattern generator
  always @(posedge clock) begin
    #1;
    case (or_mode)
      0:       oready = 1'b1;
      1:       oready = ~oready;
      default: oready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [OSIZE-1:0] w, input logic last, input logic align);
    bit ok;
    ok     = 1'b0;
    ivalid = 1'b1;
    idata  = w;
    ilast  = last;
    ialign = align;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      if (iready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("word_accept_timeout", 32'(ok), 32'd1);
    @(posedge clock);
    #1;
    ivalid = 1'b0;
    ialign = 1'b0;
    ilast  = 1'b0;
  endtask

  function automatic logic [OSIZE-1:0] rword();
    logic [OSIZE-1:0] w;
    for (int i = 0; i < OSIZE / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int olast_count(input int from, input int to);
    int n;
    n = 0;
    for (int i = from; i < to; i++) if (cap[i][ISIZE]) n++;
    return n;
  endfunction

  logic [OSIZE-1:0] w0, w1, w2, wa, wb, wc;
  int b;
  bit done;

  initial begin
    w0 = {128{2'b10}};            // bit k = k mod 2
    w1 = {8{32'h12345678}};
    w2 = {8{32'hDEADBEEF}};

    // ---- reset and idle
    rst_n = 1'b0;
    repeat (3) begin
      step();
      chk("rst_iready", 32'(iready), 32'd1);
      chk("rst_ovalid", 32'(ovalid), 32'd0);
      chk("rst_olast",  32'(olast),  32'd0);
      chk("rst_odata",  32'(odata),  32'd0);
    end
    rst_n = 1'b1;
    repeat (2) step();

    // ---- single word, then straddle into a second word
    b = cap.size();
    send_word(w0, 1'b0, 1'b1);
    repeat (14) step();
    chk("one_word_pixels", 32'(cap.size() - b), 32'd10);
    chk("pixel0", 32'(cap[b][ISIZE-1:0]),   32'hAAAAAA);
    chk("pixel9", 32'(cap[b+9][ISIZE-1:0]), 32'hAAAAAA);
    send_word(w1, 1'b0, 1'b0);
    repeat (14) step();
    chk("two_word_pixels", 32'(cap.size() - b), 32'd21);
    chk("pixel10_straddle", 32'(cap[b+10][ISIZE-1:0]), 32'hAAAA12);
    chk("pixel11",          32'(cap[b+11][ISIZE-1:0]), 32'h345678);

    // ---- same straddle under toggling backpressure
    or_mode = 1;
    b = cap.size();
    send_word(w0, 1'b0, 1'b1);
    repeat (30) step();
    send_word(w1, 1'b0, 1'b0);
    repeat (30) step();
    chk("bp_pixels",  32'(cap.size() - b), 32'd21);
    chk("bp_pixel10", 32'(cap[b+10][ISIZE-1:0]), 32'hAAAA12);
    chk("bp_pixel20", 32'(cap[b+20][ISIZE-1:0]), 32'h123456);
    or_mode = 0;

    // ---- line end: three words, the last with ilast
    wa = rword(); wb = rword(); wc = rword();
    b = cap.size();
    send_word(wa, 1'b0, 1'b1);
    send_word(wb, 1'b0, 1'b0);
    send_word(wc, 1'b1, 1'b0);
    repeat (20) step();
    chk("line3_pixels",     32'(cap.size() - b), 32'd32);
    chk("line3_last_pos",   32'(cap[b+31][ISIZE]), 32'd1);
    chk("line3_last_count", 32'(olast_count(b, cap.size())), 32'd1);
    chk("line3_empty_odata", 32'(odata), 32'd0);

    // ---- line end: two words, 8 residual bits discarded
    b = cap.size();
    send_word(wa, 1'b0, 1'b1);
    send_word(wb, 1'b1, 1'b0);
    repeat (20) step();
    chk("line2_pixels",     32'(cap.size() - b), 32'd21);
    chk("line2_last_pos",   32'(cap[b+20][ISIZE]), 32'd1);
    chk("line2_last_count", 32'(olast_count(b, cap.size())), 32'd1);
    chk("line2_discard_odata", 32'(odata), 32'd0);
    chk("line2_discard_iready", 32'(iready), 32'd1);

    // ---- mid-line flush with a new word
    b = cap.size();
    send_word(w0, 1'b0, 1'b1);
    done = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clock);
      if (cap.size() - b >= 4) begin
        done = 1'b1;
        break;
      end
    end
    chk("flush_wait_timeout", 32'(done), 32'd1);
    #1;
    send_word(w2, 1'b0, 1'b1);
    repeat (14) step();
    chk("flush_pixels",   32'(cap.size() - b), 32'd14);
    chk("flush_first_w2", 32'(cap[b+4][ISIZE-1:0]), 32'hDEADBE);
    chk("flush_second_w2", 32'(cap[b+5][ISIZE-1:0]), 32'hEFDEAD);

    // ---- reset in the middle of a line
    send_word(w0, 1'b0, 1'b1);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("midrst_iready", 32'(iready), 32'd1);
    chk("midrst_ovalid", 32'(ovalid), 32'd0);
    chk("midrst_olast",  32'(olast),  32'd0);
    chk("midrst_odata",  32'(odata),  32'd0);
    rst_n = 1'b1;
    step();

    // ---- randomized traffic
    or_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      ivalid = 1'($urandom_range(0, 3) != 0);
      idata  = rword();
      ilast  = 1'($urandom_range(0, 5) == 0);
      ialign = 1'($urandom_range(0, 40) == 0);
      step();
    end
    ivalid = 1'b0;
    ialign = 1'b0;
    ilast  = 1'b0;
    or_mode = 0;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
